// File: rtl/lighthouse_arbiter.sv
// Lighthouse decoder arbiter: synchronizes per-sensor ready levels, turns
// rising edges into pending requests, grants them round-robin into a result
// FIFO, and exposes status/head/mask through a four-word Avalon-MM slave.
module lighthouse_arbiter #(
  parameter int NUM_SENSORS = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [32*NUM_SENSORS-1:0] sensor_data_i,
  input  logic [NUM_SENSORS-1:0]    data_ready_i,
  input  logic [1:0]                address,
  input  logic                      read,
  input  logic                      write,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      waitrequest
);

  localparam int N     = NUM_SENSORS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Input conditioning
  logic [N-1:0] sync1_reg;
  logic [N-1:0] sync2_reg;
  logic [N-1:0] prev_reg;
  logic [1:0]   prime_reg;
  logic         primed;
  logic [N-1:0] rise;
  logic [N-1:0] rise_masked;
  logic [31:0]  sensor_word [N];

  // Request / control state
  logic [N-1:0] pending_reg;
  logic [N-1:0] pending_next;
  logic [N-1:0] mask_reg;
  logic [N-1:0] mask_next;
  logic         overrun_reg;
  logic         overrun_next;
  logic         overrun_event;
  logic [3:0]   last_grant_reg;

  // Arbiter result
  logic         grant_valid;
  logic [3:0]   grant_id;
  logic [31:0]  grant_data;
  logic [N-1:0] grant_vec;

  // Result FIFO
  logic [3:0]       id_mem   [FIFO_DEPTH];
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;

  // Bus decode
  logic mask_wr;
  logic status_wr;
  logic unused_writedata;

  assign waitrequest      = 1'b0;
  assign unused_writedata = &{1'b0, writedata};

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop        = read && (address == 2'd2) && !fifo_empty;
  assign mask_wr    = write && (address == 2'd3);
  assign status_wr  = write && (address == 2'd0);

  // Edge detection stays disabled until the synchronizer chain has refilled
  // after reset, so a level already high at release never looks like a rise.
  assign primed = (prime_reg == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sensor
      assign sensor_word[gi] = sensor_data_i[32*gi +: 32];
      assign rise[gi]        = sync2_reg[gi] & ~prev_reg[gi] & primed;
    end
  endgenerate

  assign rise_masked = rise & mask_reg;

  // Two-flop synchronizer, edge-detector history and post-reset priming count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
      prime_reg <= 2'd0;
    end else begin
      sync1_reg <= data_ready_i;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      if (prime_reg != 2'd3) begin
        prime_reg <= prime_reg + 2'd1;
      end
    end
  end

  // Round-robin search starting one past the last granted sensor
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_data  = '0;
    grant_vec   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant_reg) + k) % N;
      if (!grant_valid && !fifo_full && pending_reg[idx]) begin
        grant_valid    = 1'b1;
        grant_id       = 4'(idx);
        grant_data     = sensor_word[idx];
        grant_vec[idx] = 1'b1;
      end
    end
  end

  // Next-state for pending, mask and the sticky overrun flag
  always_comb begin
    mask_next     = mask_wr ? writedata[N-1:0] : mask_reg;
    // A rise during the grant cycle re-arms the request: the granted word is
    // already stale, so the sensor must be served again.
    pending_next  = ((pending_reg & ~grant_vec) | rise_masked) & mask_next;
    overrun_event = |(rise_masked & pending_reg);
    overrun_next  = overrun_reg;
    if (overrun_event) begin
      overrun_next = 1'b1;
    end else if (status_wr && writedata[2]) begin
      overrun_next = 1'b0;
    end
  end

  // Control registers, arbiter history and FIFO bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg    <= '0;
      mask_reg       <= '1;
      overrun_reg    <= 1'b0;
      last_grant_reg <= 4'(N - 1);
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      pending_reg <= pending_next;
      mask_reg    <= mask_next;
      overrun_reg <= overrun_next;
      if (grant_valid) begin
        last_grant_reg <= grant_id;
        wr_ptr_reg     <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({grant_valid, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage: contents need no reset, pointers define validity
  always_ff @(posedge clock) begin
    if (grant_valid) begin
      id_mem[wr_ptr_reg]   <= grant_id;
      data_mem[wr_ptr_reg] <= grant_data;
    end
  end

  // Register read mux; reflects state before any same-cycle write or pop
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[0]          = fifo_empty;
        readdata[1]          = fifo_full;
        readdata[2]          = overrun_reg;
        readdata[8 +: CNT_W] = count_reg;
        readdata[16 +: N]    = pending_reg;
      end
      2'd1: begin
        if (!fifo_empty) begin
          readdata[3:0] = id_mem[rd_ptr_reg];
        end
      end
      2'd2: begin
        if (!fifo_empty) begin
          readdata = data_mem[rd_ptr_reg];
        end
      end
      default: begin
        readdata[N-1:0] = mask_reg;
      end
    endcase
  end

endmodule

// File: tb/tb_lighthouse_arbiter.sv
// Scoreboard bench for lighthouse_arbiter: expected FIFO entries are queued
// when sensors are raised and compared as the bus drains the FIFO.
module tb_lighthouse_arbiter;

  localparam int N = 16;
  localparam int D = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [32*N-1:0] sensor_data_i = '0;
  logic [N-1:0]    data_ready_i = '0;
  logic [1:0]      address = 2'd0;
  logic            read = 1'b0;
  logic            write = 1'b0;
  logic [31:0]     writedata = '0;
  logic [31:0]     readdata;
  logic            waitrequest;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } entry_t;

  entry_t exp_q[$];

  lighthouse_arbiter #(.NUM_SENSORS(N), .FIFO_DEPTH(D)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sensor_data_i(sensor_data_i),
    .data_ready_i (data_ready_i),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .waitrequest  (waitrequest)
  );

  always #5 clock = ~clock;

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clock);
    write     = 1'b0;
    writedata = '0;
  endtask

  task automatic bus_pop(output logic [31:0] d);
    address = 2'd2;
    read    = 1'b1;
    #1;
    d = readdata;
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic apply_reset();
    data_ready_i = '0;
    reset_n      = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(4);
    exp_q.delete();
  endtask

  task automatic raise(input logic [N-1:0] bits, input logic [31:0] base);
    for (int i = 0; i < N; i++) begin
      if (bits[i]) sensor_data_i[32*i +: 32] = base + 32'(i);
    end
    data_ready_i = data_ready_i | bits;
  endtask

  task automatic push_exp(input int id, input logic [31:0] data);
    entry_t e;
    e.id   = 4'(id);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_count(input int target, input int budget);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    s  = '0;
    tests_run++;
    for (int c = 0; c < budget; c++) begin
      peek(2'd0, s);
      if (int'(s[15:8]) == target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      tests_failed++;
      $display("FAIL wait_count: count=%0d required=%0d", s[15:8], target);
    end
  endtask

  task automatic scoreboard_drain(input int n);
    logic [31:0] s;
    logic [31:0] d;
    entry_t e;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 20; c++) begin
        peek(2'd0, s);
        if (!s[0]) break;
        @(negedge clock);
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL drain_queue: scoreboard empty at entry %0d", k);
      end else begin
        e = exp_q.pop_front();
        peek(2'd1, s);
        if (s !== {28'h0, e.id}) begin
          tests_failed++;
          $display("FAIL drain_id: got %0d required %0d", s, e.id);
        end
        bus_pop(d);
        tests_run++;
        if (d !== e.data) begin
          tests_failed++;
          $display("FAIL drain_data: got 0x%08h required 0x%08h", d, e.data);
        end
        $display("[TB] pop id=%0d data=0x%08h", e.id, d);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] s;
    apply_reset();
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0001) begin tests_failed++; $display("FAIL reset_reg0: got 0x%08h required 0x00000001", s); end
    peek(2'd1, s); tests_run++;
    if (s !== 32'h0) begin tests_failed++; $display("FAIL reset_reg1: got 0x%08h required 0x00000000", s); end
    peek(2'd2, s); tests_run++;
    if (s !== 32'h0) begin tests_failed++; $display("FAIL reset_reg2: got 0x%08h required 0x00000000", s); end
    peek(2'd3, s); tests_run++;
    if (s !== 32'h0000_FFFF) begin tests_failed++; $display("FAIL reset_reg3: got 0x%08h required 0x0000ffff", s); end
    tests_run++;
    if (waitrequest !== 1'b0) begin tests_failed++; $display("FAIL waitrequest: got %b required 0", waitrequest); end
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    logic [31:0] s;
    apply_reset();
    sensor_data_i[32*2 +: 32] = 32'h1234_5678;
    data_ready_i[2] = 1'b1;
    push_exp(2, 32'h1234_5678);
    cycles(3);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0004_0001) begin tests_failed++; $display("FAIL single_pending: got 0x%08h required 0x00040001", s); end
    cycles(1);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0100) begin tests_failed++; $display("FAIL single_count: got 0x%08h required 0x00000100", s); end
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0100) begin tests_failed++; $display("FAIL single_ignored_write: got 0x%08h required 0x00000100", s); end
    scoreboard_drain(1);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0001) begin tests_failed++; $display("FAIL single_after_pop: got 0x%08h required 0x00000001", s); end
    data_ready_i = '0;
    cycles(4);
  endtask

  task automatic test_round_robin();
    apply_reset();
    raise(16'h8021, 32'hD000_0000);
    push_exp(0, 32'hD000_0000);
    push_exp(5, 32'hD000_0005);
    push_exp(15, 32'hD000_000F);
    wait_count(3, 30);
    scoreboard_drain(3);
    data_ready_i = '0;
    cycles(4);
    raise(16'h0021, 32'hE000_0000);
    push_exp(0, 32'hE000_0000);
    push_exp(5, 32'hE000_0005);
    wait_count(2, 30);
    scoreboard_drain(2);
    data_ready_i = '0;
    cycles(4);
  endtask

  task automatic test_full();
    logic [31:0] s;
    apply_reset();
    raise(16'h03FF, 32'hA000_0000);
    for (int i = 0; i < 10; i++) push_exp(i, 32'hA000_0000 + 32'(i));
    wait_count(8, 30);
    cycles(2);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0300_0802) begin tests_failed++; $display("FAIL full_status: got 0x%08h required 0x03000802", s); end
    scoreboard_drain(2);
    cycles(3);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0802) begin tests_failed++; $display("FAIL full_refill: got 0x%08h required 0x00000802", s); end
    scoreboard_drain(8);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0001) begin tests_failed++; $display("FAIL full_empty: got 0x%08h required 0x00000001", s); end
    data_ready_i = '0;
    cycles(4);
  endtask

  task automatic test_overrun();
    logic [31:0] s;
    apply_reset();
    raise(16'h01F7, 32'hB000_0000);
    push_exp(0, 32'hB000_0000);
    push_exp(1, 32'hB000_0001);
    push_exp(2, 32'hB000_0002);
    for (int i = 4; i <= 8; i++) push_exp(i, 32'hB000_0000 + 32'(i));
    wait_count(8, 30);
    sensor_data_i[32*3 +: 32] = 32'h3333_0003;
    data_ready_i[3] = 1'b1;
    cycles(4);
    data_ready_i[3] = 1'b0;
    cycles(3);
    data_ready_i[3] = 1'b1;
    cycles(4);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0008_0806) begin tests_failed++; $display("FAIL overrun_set: got 0x%08h required 0x00080806", s); end
    bus_write(2'd0, 32'h0000_0004);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0008_0802) begin tests_failed++; $display("FAIL overrun_clear: got 0x%08h required 0x00080802", s); end
    push_exp(3, 32'h3333_0003);
    scoreboard_drain(9);
    cycles(2);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0001) begin tests_failed++; $display("FAIL overrun_single_entry: got 0x%08h required 0x00000001", s); end
    data_ready_i = '0;
    cycles(4);
  endtask

  task automatic test_mask();
    logic [31:0] s;
    apply_reset();
    bus_write(2'd3, 32'h0000_FFFE);
    peek(2'd3, s); tests_run++;
    if (s !== 32'h0000_FFFE) begin tests_failed++; $display("FAIL mask_readback: got 0x%08h required 0x0000fffe", s); end
    sensor_data_i[31:0] = 32'hDEAD_0000;
    data_ready_i[0] = 1'b1;
    cycles(6);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0001) begin tests_failed++; $display("FAIL mask_no_entry: got 0x%08h required 0x00000001", s); end
    bus_pop(s); tests_run++;
    if (s !== 32'h0) begin tests_failed++; $display("FAIL mask_empty_pop: got 0x%08h required 0x00000000", s); end
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0001) begin tests_failed++; $display("FAIL mask_count_stays: got 0x%08h required 0x00000001", s); end
    address   = 2'd3;
    writedata = 32'h0000_FFFF;
    write     = 1'b1;
    #1;
    s = readdata; tests_run++;
    if (s !== 32'h0000_FFFE) begin tests_failed++; $display("FAIL rw_same_cycle: got 0x%08h required 0x0000fffe", s); end
    @(negedge clock);
    write = 1'b0;
    peek(2'd3, s); tests_run++;
    if (s !== 32'h0000_FFFF) begin tests_failed++; $display("FAIL rw_write_taken: got 0x%08h required 0x0000ffff", s); end
    data_ready_i = '0;
    cycles(4);
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    apply_reset();
    bus_write(2'd3, 32'h0000_0F0F);
    raise(16'h000F, 32'hC000_0000);
    wait_count(4, 30);
    reset_n = 1'b0;
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0001) begin tests_failed++; $display("FAIL midreset_reg0: got 0x%08h required 0x00000001", s); end
    peek(2'd3, s); tests_run++;
    if (s !== 32'h0000_FFFF) begin tests_failed++; $display("FAIL midreset_reg3: got 0x%08h required 0x0000ffff", s); end
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    cycles(10);
    peek(2'd0, s); tests_run++;
    if (s !== 32'h0000_0001) begin tests_failed++; $display("FAIL midreset_no_edge: got 0x%08h required 0x00000001", s); end
    data_ready_i = '0;
    cycles(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_overrun();
    test_mask();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lighthouse_arbiter.md
LIGHTHOUSE_ARBITER -- requirements
Module: lighthouse_arbiter

Interface
REQ-001 Parameter NUM_SENSORS, default 16: number of lighthouse decoder requesters (2..16).
REQ-002 Parameter FIFO_DEPTH, default 8: result FIFO entries (power of two, 2..64).
REQ-003 clock  input  1: single clock for all logic.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 sensor_data_i  input  32*NUM_SENSORS: decoder result words, sensor i at bits [32i+31:32i], stable while its data_ready_i bit is high.
REQ-006 data_ready_i  input  NUM_SENSORS: decoder ready levels, asynchronous to clock.
REQ-007 address  input  2: Avalon word address.
REQ-008 read  input  1: Avalon read strobe.
REQ-009 write  input  1: Avalon write strobe.
REQ-010 writedata  input  32: Avalon write data.
REQ-011 readdata  output  32: Avalon read data, combinational from address.
REQ-012 waitrequest  output  1: tied 0.

Function
REQ-013 Each data_ready_i bit shall pass through a 2-flop synchronizer; rising edge detected on the synchronized copy.
REQ-014 A detected rising edge on sensor i with mask[i]=1 shall set pending[i]; with mask[i]=0 it shall be ignored.
REQ-015 Pending set occurs 3 clock edges after the input rise is first sampled.
REQ-016 Each cycle with pending!=0 and FIFO count<FIFO_DEPTH, exactly one sensor shall be granted, round-robin: search starts at last_grant+1 mod NUM_SENSORS; last_grant resets to NUM_SENSORS-1 (first search starts at 0).
REQ-017 Grant shall write {id, sensor_data_i[i]} into the FIFO and clear pending[i] at the same edge; earliest FIFO write is 1 edge after pending set.
REQ-018 New edge on sensor i while pending[i]=1, or in the grant cycle of i, shall leave pending[i]=1 and set sticky overrun bit.
REQ-019 FIFO full (count==FIFO_DEPTH): no grant; pendings held; no data lost beyond REQ-018.
REQ-020 Full-condition for grant uses count before any same-cycle pop; simultaneous push and pop leaves count unchanged.
REQ-021 Register 0 (status, R): [0] empty, [1] full, [2] overrun, [8:15] count, [31:16] pending.
REQ-022 Register 0 write with writedata[2]=1 shall clear overrun; simultaneous new overrun event wins (bit stays 1).
REQ-023 Register 1 (R): head sensor id in [3:0], zero-extended; no pop; 0 when empty.
REQ-024 Register 2 (R): head data word; read strobe pops one entry; 0 and no state change when empty.
REQ-025 Register 3 (RW): mask[NUM_SENSORS-1:0]; clearing a mask bit shall also clear that pending bit next edge; unused bits read 0.
REQ-026 Writes to registers 1 and 2 shall be ignored.
REQ-027 Read and write in the same cycle: write shall take effect, read returns pre-write value.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-029 reset_n low shall asynchronously clear synchronizers, edge detectors, pending, overrun, FIFO pointers and count, last_grant to NUM_SENSORS-1, and set mask to all ones.
REQ-030 After reset readdata: reg0 = 0x0000_0001, reg1 = 0, reg2 = 0, reg3 = 0x0000_FFFF (default parameters).
REQ-031 Reset asserted mid-operation shall discard all FIFO contents and pendings; an input held high across reset release shall not produce an edge.

Verification
REQ-032 Sensor 2 rises with data 0x1234_5678 -> reg0 count=1 within 5 edges; reg1=2; reg2 read returns 0x1234_5678; then reg0=0x0000_0001.
REQ-033 Sensors 0, 5, 15 rise same cycle -> FIFO ids in order 0,5,15; next simultaneous burst of 0 and 5 yields 0 then 5 (pointer after 15 wraps).
REQ-034 Ten distinct sensors rise with no pops -> count=8, full=1, two pending bits set; two reg2 reads -> count returns to 8, pending=0.
REQ-035 Sensor 3 rises twice before grant (FIFO full) -> overrun=1, one entry for 3; write reg0 0x4 -> overrun=0.
REQ-036 Write reg3=0xFFFE then sensor 0 rises -> no entry, pending[0]=0; reg2 read on empty returns 0, count stays 0.
REQ-037 Reset pulse with 4 entries queued -> reg0=0x0000_0001 immediately, reg3=0x0000_FFFF.
